// File: rtl/text_fetch8x12.sv
// Text-mode front end: 80x40 grid of 8x12 cells, text RAM fetch, 16-entry palette, blinking cursor.
// Latency 2 clocks from i_pixel_en to o_valid; no backpressure, one pixel per enabled cycle.
module text_fetch8x12 #(
  parameter int COLS = 80,
  parameter int ROWS = 40
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame_start,
  input  logic        i_line_end,
  input  logic        i_pixel_en,
  output logic [11:0] o_ram_addr,
  input  logic [15:0] i_ram_data,
  input  logic        i_reg_we,
  input  logic [4:0]  i_reg_addr,
  input  logic [11:0] i_reg_data,
  output logic        o_valid,
  output logic [7:0]  o_char,
  output logic [3:0]  o_row,
  output logic [2:0]  o_column,
  output logic [11:0] o_fg_color,
  output logic [11:0] o_bg_color
);

  logic [2:0]  col_cnt_q, col_cnt_d;
  logic [6:0]  cell_col_q, cell_col_d;
  logic [3:0]  row_cnt_q, row_cnt_d;
  logic [5:0]  cell_row_q, cell_row_d;
  logic [4:0]  frame_cnt_q, frame_cnt_d;

  logic [11:0] pal_q [16];
  logic [6:0]  cursor_col_q;
  logic [5:0]  cursor_row_q;
  logic [1:0]  ctrl_q;

  logic        s1_vld_q, s1_hit_q;
  logic [3:0]  s1_row_q;
  logic [2:0]  s1_col_q;

  logic        out_vld_q;
  logic [7:0]  out_char_q;
  logic [3:0]  out_row_q;
  logic [2:0]  out_col_q;
  logic [11:0] out_fg_q, out_bg_q;

  logic        cursor_hit;
  logic [11:0] fg_lookup, bg_lookup;

  always_comb begin
    col_cnt_d   = col_cnt_q;
    cell_col_d  = cell_col_q;
    row_cnt_d   = row_cnt_q;
    cell_row_d  = cell_row_q;
    frame_cnt_d = frame_cnt_q;
    if (i_frame_start) begin
      col_cnt_d   = '0;
      cell_col_d  = '0;
      row_cnt_d   = '0;
      cell_row_d  = '0;
      frame_cnt_d = frame_cnt_q + 5'd1;
    end else if (i_line_end) begin
      col_cnt_d  = '0;
      cell_col_d = '0;
      if (row_cnt_q == 4'd11) begin
        row_cnt_d  = '0;
        cell_row_d = (cell_row_q == 6'(ROWS - 1)) ? 6'd0 : cell_row_q + 6'd1;
      end else begin
        row_cnt_d = row_cnt_q + 4'd1;
      end
    end else if (i_pixel_en) begin
      col_cnt_d = col_cnt_q + 3'd1;
      if (col_cnt_q == 3'd7)
        cell_col_d = (cell_col_q == 7'(COLS - 1)) ? 7'd0 : cell_col_q + 7'd1;
    end
  end

  assign o_ram_addr = 12'(cell_row_q) * 12'(COLS) + 12'(cell_col_q);

  // Underline occupies the bottom two scanlines of the cursor cell.
  assign cursor_hit = ctrl_q[0] && (cell_col_q == cursor_col_q) && (cell_row_q == cursor_row_q) &&
                      (row_cnt_q >= 4'd10) && (!ctrl_q[1] || frame_cnt_q[4]);

  assign fg_lookup = pal_q[i_ram_data[11:8]];
  assign bg_lookup = pal_q[i_ram_data[15:12]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_cnt_q    <= '0;
      cell_col_q   <= '0;
      row_cnt_q    <= '0;
      cell_row_q   <= '0;
      frame_cnt_q  <= '0;
      cursor_col_q <= '0;
      cursor_row_q <= '0;
      ctrl_q       <= '0;
      for (int i = 0; i < 16; i++) pal_q[i] <= '0;
    end else begin
      col_cnt_q   <= col_cnt_d;
      cell_col_q  <= cell_col_d;
      row_cnt_q   <= row_cnt_d;
      cell_row_q  <= cell_row_d;
      frame_cnt_q <= frame_cnt_d;
      if (i_reg_we) begin
        if (!i_reg_addr[4])          pal_q[i_reg_addr[3:0]] <= i_reg_data;
        else if (i_reg_addr == 5'd16) cursor_col_q <= i_reg_data[6:0];
        else if (i_reg_addr == 5'd17) cursor_row_q <= i_reg_data[5:0];
        else if (i_reg_addr == 5'd18) ctrl_q       <= i_reg_data[1:0];
      end
    end
  end

  // Stage 1 carries side data while the RAM read is in flight; stage 2 resolves colours.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
      out_vld_q  <= 1'b0;
      out_char_q <= '0;
      out_row_q  <= '0;
      out_col_q  <= '0;
      out_fg_q   <= '0;
      out_bg_q   <= '0;
    end else begin
      s1_vld_q  <= i_pixel_en;
      out_vld_q <= s1_vld_q;
      if (i_pixel_en) begin
        s1_hit_q <= cursor_hit;
        s1_row_q <= row_cnt_q;
        s1_col_q <= col_cnt_q;
      end
      if (s1_vld_q) begin
        out_char_q <= i_ram_data[7:0];
        out_row_q  <= s1_row_q;
        out_col_q  <= s1_col_q;
        out_fg_q   <= s1_hit_q ? bg_lookup : fg_lookup;
        out_bg_q   <= s1_hit_q ? fg_lookup : bg_lookup;
      end
    end
  end

  assign o_valid    = out_vld_q;
  assign o_char     = out_char_q;
  assign o_row      = out_row_q;
  assign o_column   = out_col_q;
  assign o_fg_color = out_fg_q;
  assign o_bg_color = out_bg_q;

endmodule

// File: tb/tb_text_fetch8x12.sv
// Scoreboard bench for text_fetch8x12: directed stimulus, expectations queued at issue, monitor compares.
`timescale 1ns/1ps
module tb_text_fetch8x12;
  localparam int COLS = 80;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_frame_start = 1'b0, i_line_end = 1'b0, i_pixel_en = 1'b0;
  logic [11:0] o_ram_addr;
  logic [15:0] i_ram_data;
  logic        i_reg_we = 1'b0;
  logic [4:0]  i_reg_addr = '0;
  logic [11:0] i_reg_data = '0;
  logic        o_valid;
  logic [7:0]  o_char;
  logic [3:0]  o_row;
  logic [2:0]  o_column;
  logic [11:0] o_fg_color, o_bg_color;

  text_fetch8x12 #(.COLS(80), .ROWS(40)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_start(i_frame_start), .i_line_end(i_line_end),
    .i_pixel_en(i_pixel_en), .o_ram_addr(o_ram_addr), .i_ram_data(i_ram_data),
    .i_reg_we(i_reg_we), .i_reg_addr(i_reg_addr), .i_reg_data(i_reg_data),
    .o_valid(o_valid), .o_char(o_char), .o_row(o_row), .o_column(o_column),
    .o_fg_color(o_fg_color), .o_bg_color(o_bg_color));

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0]  ch;
    logic [3:0]  row;
    logic [2:0]  col;
    logic [11:0] fg;
    logic [11:0] bg;
  } exp_t;

  int   errors = 0, checks = 0, swaps = 0;
  exp_t sb[$];

  // Text RAM stand-in: one-cycle read latency, content derived from the address.
  function automatic logic [15:0] ram_word(input logic [11:0] a);
    return {4'h2, 4'h1, a[7:0] ^ 8'h41};
  endfunction
  logic [15:0] ram_q = '0;
  always @(posedge i_clk) ram_q <= ram_word(o_ram_addr);
  assign i_ram_data = ram_q;

  // Reference state
  int          mcol = 0, mccol = 0, mrow = 0, mcrow = 0, mframe = 0, ccol = 0, crow = 0;
  logic [1:0]  mctrl = '0;
  logic [11:0] mpal [16];
  bit          pend_v = 0, phit;
  logic [7:0]  pch;
  logic [3:0]  prow, pfgi, pbgi;
  logic [2:0]  pcol;

  function automatic int maddr();
    return mcrow * COLS + mccol;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic model_reset();
    mcol = 0; mccol = 0; mrow = 0; mcrow = 0; mframe = 0; ccol = 0; crow = 0; mctrl = '0;
    for (int i = 0; i < 16; i++) mpal[i] = '0;
    pend_v = 0;
  endtask

  task automatic cyc(input bit fs, input bit le, input bit pe, input bit we,
                     input logic [4:0] ra, input logic [11:0] rd);
    logic [15:0] w;
    logic [11:0] f, b;
    chk("ram_addr", int'(o_ram_addr), maddr());
    if (pend_v) begin
      f = mpal[pfgi]; b = mpal[pbgi];
      if (phit) sb.push_back({pch, prow, pcol, b, f});
      else      sb.push_back({pch, prow, pcol, f, b});
      pend_v = 0;
    end
    if (pe) begin
      w = ram_word(12'(maddr()));
      pch = w[7:0]; pfgi = w[11:8]; pbgi = w[15:12];
      prow = 4'(mrow); pcol = 3'(mcol);
      phit = mctrl[0] && mccol == ccol && mcrow == crow && mrow >= 10 && (!mctrl[1] || mframe >= 16);
      pend_v = 1;
    end
    i_frame_start = fs; i_line_end = le; i_pixel_en = pe;
    i_reg_we = we; i_reg_addr = ra; i_reg_data = rd;
    @(posedge i_clk); #1;
    i_frame_start = 0; i_line_end = 0; i_pixel_en = 0; i_reg_we = 0;
    if (we) begin
      if (ra < 16)       mpal[ra[3:0]] = rd;
      else if (ra == 16) ccol = int'(rd[6:0]);
      else if (ra == 17) crow = int'(rd[5:0]);
      else if (ra == 18) mctrl = rd[1:0];
    end
    if (fs) begin
      mcol = 0; mccol = 0; mrow = 0; mcrow = 0; mframe = (mframe + 1) % 32;
    end else if (le) begin
      mcol = 0; mccol = 0;
      if (mrow == 11) begin mrow = 0; mcrow = (mcrow + 1) % 40; end
      else mrow++;
    end else if (pe) begin
      if (mcol == 7) begin mcol = 0; mccol = (mccol + 1) % COLS; end
      else mcol++;
    end
  endtask

  task automatic px();   cyc(0, 0, 1, 0, 5'd0, 12'd0); endtask
  task automatic le();   cyc(0, 1, 0, 0, 5'd0, 12'd0); endtask
  task automatic fs();   cyc(1, 0, 0, 0, 5'd0, 12'd0); endtask
  task automatic idle(input int n); repeat (n) cyc(0, 0, 0, 0, 5'd0, 12'd0); endtask
  task automatic wr(input logic [4:0] a, input logic [11:0] d); cyc(0, 0, 0, 1, a, d); endtask

  task automatic cursor_sweep();
    fs();
    repeat (24) le();
    repeat (12) begin repeat (48) px(); le(); end
    idle(3);
  endtask

  // Independent 2-cycle valid delay line
  logic pd1, pd2;
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin pd1 <= 0; pd2 <= 0; end
    else begin pd1 <= i_pixel_en; pd2 <= pd1; end
  end

  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst_n) begin
      checks++;
      if (o_valid !== pd2) begin
        errors++;
        $display("FAIL valid_timing: got %b expected %b", o_valid, pd2);
      end
      if (o_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel: got char=%h with none expected", o_char);
        end else begin
          e = sb.pop_front();
          if ({o_char, o_row, o_column, o_fg_color, o_bg_color} !== e) begin
            errors++;
            $display("FAIL pixel: got ch=%h row=%0d col=%0d fg=%h bg=%h expected ch=%h row=%0d col=%0d fg=%h bg=%h",
                     o_char, o_row, o_column, o_fg_color, o_bg_color, e.ch, e.row, e.col, e.fg, e.bg);
          end
        end
        if (o_fg_color == 12'h0F0 && o_bg_color == 12'hF00) swaps++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_addr", int'(o_ram_addr), 0);
    chk("rst_colors", int'({o_fg_color, o_bg_color}), 0);
    i_rst_n = 1;
    idle(2);

    // Basic fetch: char 0x41, fg F00, bg 0F0, columns 0..2
    wr(5'd1, 12'hF00);
    wr(5'd2, 12'h0F0);
    wr(5'd25, 12'hABC);
    fs();
    repeat (3) px();
    idle(3);

    // Cell column stepping and wrap at 80 cells
    fs();
    repeat (8) px();
    chk("addr_ninth_pixel", int'(o_ram_addr), 1);
    repeat (632) px();
    chk("addr_col_wrap", int'(o_ram_addr), 0);
    px();
    le();
    idle(3);

    // Cell row stepping and wrap at 40 cell rows
    fs();
    repeat (12) begin repeat (640) px(); le(); end
    chk("addr_line13", int'(o_ram_addr), 80);
    px();
    le();
    repeat (467) le();
    chk("addr_row_wrap", int'(o_ram_addr), 0);
    idle(3);

    // Steady cursor at cell (5,2): 2 rows x 8 pixels swapped
    wr(5'd16, 12'd5);
    wr(5'd17, 12'd2);
    wr(5'd18, 12'd1);
    s0 = swaps;
    cursor_sweep();
    chk("cursor_swaps", swaps - s0, 16);

    // Blinking cursor: hidden in frame 15, shown in frame 16
    wr(5'd18, 12'd3);
    while (mframe != 14) fs();
    s0 = swaps;
    cursor_sweep();
    chk("blink_off_swaps", swaps - s0, 0);
    s0 = swaps;
    cursor_sweep();
    chk("blink_on_swaps", swaps - s0, 16);

    // Palette write colliding with the lookup of the previous pixel
    fs();
    px();
    cyc(0, 0, 1, 1, 5'd1, 12'h00F);
    idle(3);

    // Reset with two pixels in flight at a nonzero address
    fs();
    repeat (12) le();
    px();
    px();
    i_rst_n = 0;
    #1;
    chk("midrst_valid", int'(o_valid), 0);
    chk("midrst_addr", int'(o_ram_addr), 0);
    chk("midrst_char", int'(o_char), 0);
    chk("midrst_colors", int'({o_fg_color, o_bg_color}), 0);
    sb.delete();
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1;
    idle(4);
    fs();
    px();
    idle(4);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/text_fetch8x12.md
# text_fetch8x12

Per-pixel text-mode front end feeding the 8x12 character blender. Tracks the on-screen position as an 80x40 grid of 8x12 cells, reads each cell's character and attribute word from text RAM, resolves foreground/background colours through a 16-entry 12-bit palette, and applies a blinking underline cursor. Outputs a pipelined stream of character code, cell row/column and colours that connects directly to the blender inputs.

## Interface

Parameters:
- COLS, 80, text columns per row
- ROWS, 40, text rows per frame

Ports:
- i_clk  in  1  pixel clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_frame_start  in  1  one-cycle pulse before the first active line
- i_line_end  in  1  one-cycle pulse after the last active pixel of a line
- i_pixel_en  in  1  active pixel strobe; one pixel per asserted cycle
- o_ram_addr  out  12  text RAM word address = cell_row*COLS + cell_col
- i_ram_data  in  16  RAM word, valid the cycle after address: [7:0] char, [11:8] fg index, [15:12] bg index
- i_reg_we  in  1  register write strobe
- i_reg_addr  in  5  0-15 palette, 16 cursor column, 17 cursor row, 18 control
- i_reg_data  in  12  write data; control bit0 cursor enable, bit1 blink enable
- o_valid  out  1  outputs below carry a pixel
- o_char  out  8  character code
- o_row  out  4  row within cell, 0-11
- o_column  out  3  column within cell, 0-7
- o_fg_color  out  12  foreground colour
- o_bg_color  out  12  background colour

## Operation

- Position counters: col_cnt (0-7), cell_col (0-COLS-1), row_cnt (0-11), cell_row (0-ROWS-1), all registered.
- Priority per cycle: i_frame_start > i_line_end > i_pixel_en.
- i_frame_start: all four counters to 0; frame_cnt (5-bit) increments, wraps 31->0.
- i_line_end: col_cnt, cell_col to 0; row_cnt increments; 11->0 increments cell_row; cell_row ROWS-1 -> 0.
- i_pixel_en (alone): col_cnt increments; 7->0 increments cell_col; cell_col COLS-1 -> 0.
- i_pixel_en coinciding with i_line_end or i_frame_start: the pixel is still launched into the pipeline with pre-update counter values; counters follow the higher-priority event only.
- o_ram_addr combinational from counter registers; 12-bit product, max 3199.
- Cursor hit: cell_col==cursor_col, cell_row==cursor_row, row_cnt in {10,11}, cursor enable=1, and (blink enable=0 or frame_cnt[4]=1). On hit, fg and bg colours are swapped.
- Register writes: palette entry i_reg_addr[3:0] for 0-15; cursor col/row use i_reg_data[6:0]/[5:0]; control uses [1:0]; addresses 19-31 ignored. Write takes effect on the clock edge; a lookup in the same cycle sees the old value.

## Timing

- Stage 0 (cycle T): i_pixel_en=1, o_ram_addr presented; cursor hit, row_cnt, col_cnt captured at edge ending T.
- Stage 1 (T+1): i_ram_data sampled at edge ending T+1 with stage-0 side data.
- Stage 2: palette lookup and cursor swap registered at edge ending T+1... outputs valid during T+2; total latency 2 clocks from i_pixel_en to o_valid.
- o_valid follows i_pixel_en delayed by exactly 2 cycles; back-to-back pixels produce back-to-back outputs, no bubbles.
- Reset (async assert, sync release): all counters, frame_cnt, cursor regs, control, all 16 palette entries, all pipeline registers and outputs = 0. Reset mid-line discards in-flight pixels; o_valid=0 until 2 cycles after the first post-reset i_pixel_en.

## Test plan

- Reset then frame_start, 3 pixels with RAM returning 0x21_41, palette[1]=0xF00, palette[2]=0x0F0 -> o_valid at T+2..T+4, o_char=0x41, o_fg=0xF00, o_bg=0x0F0, o_column 0,1,2, o_row 0.
- 8 consecutive pixels then 1 more -> o_ram_addr 0 for first 8, 1 for ninth; after 80 cells with no line_end, cell_col wraps and o_ram_addr returns to 0.
- 12 lines of 640 pixels each followed by line_end -> line 13 first pixel has o_ram_addr=80, o_row=0; after 480 lines cell_row wraps to 0.
- Cursor at (5,2), enable=1, blink=0 -> pixels in cell 165 rows 10-11 have fg/bg swapped; rows 0-9 not swapped; blink=1 -> swap only when frame_cnt[4]=1 (frames 16-31).
- Palette write to entry 1 in same cycle as stage-2 lookup of entry 1 -> old colour output; next pixel shows new colour.
- Assert i_rst_n=0 mid-pipeline with 2 pixels in flight -> o_valid, outputs, o_ram_addr immediately 0; no stale pixel emitted after release.
